// File: rtl/udp_cmd_rx.sv
// UDP payload command decoder: parses header + data words into a registered,
// backpressured write port; reports/drains malformed packets and counts outcomes.
module udp_cmd_rx #(
   parameter int unsigned MAX_LEN   = 64,
   parameter logic [7:0]  OPCODE_WR = 8'hA5
) (
   input  logic        aclk,
   input  logic        areset,
   input  logic [31:0] s_axis_tdata,
   input  logic        s_axis_tvalid,
   input  logic        s_axis_tlast,
   output logic        s_axis_tready,
   output logic        wr_en,
   output logic [15:0] wr_addr,
   output logic [31:0] wr_data,
   input  logic        wr_ready,
   output logic        cmd_done,
   output logic        cmd_err,
   output logic [1:0]  err_code,
   output logic [15:0] pkt_cnt,
   output logic [15:0] err_cnt
);

   typedef enum logic [1:0] {
      S_HDR,
      S_DATA,
      S_DRAIN
   } state_t;

   state_t      state, state_nxt;
   logic [15:0] addr_q;
   logic [7:0]  remaining;
   logic        tready_int;
   logic        hdr_ok;
   logic        load_hdr;
   logic        load_word;
   logic        done_set;
   logic        err_set;
   logic [1:0]  err_sel;

   assign hdr_ok = (s_axis_tdata[31:24] == OPCODE_WR) &&
                   (s_axis_tdata[23:16] != 8'd0) &&
                   (32'(s_axis_tdata[23:16]) <= MAX_LEN);

   // tready is masked while reset is held so every output reads 0 in reset
   assign s_axis_tready = tready_int & ~areset;

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) state <= S_HDR;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      tready_int = 1'b0;
      load_hdr   = 1'b0;
      load_word  = 1'b0;
      done_set   = 1'b0;
      err_set    = 1'b0;
      err_sel    = 2'b00;
      case (state)
         S_HDR: begin
            tready_int = 1'b1;
            if (s_axis_tvalid) begin
               // a bad opcode/LEN is reported as bad header even on a one-word packet
               if (!hdr_ok) begin
                  err_set = 1'b1;
                  err_sel = 2'b01;
                  if (!s_axis_tlast) state_nxt = S_DRAIN;
               end else if (s_axis_tlast) begin
                  err_set = 1'b1;
                  err_sel = 2'b10;
               end else begin
                  load_hdr  = 1'b1;
                  state_nxt = S_DATA;
               end
            end
         end
         S_DATA: begin
            tready_int = ~wr_en | wr_ready;
            if (s_axis_tvalid && tready_int) begin
               load_word = 1'b1;
               if (remaining == 8'd1) begin
                  if (s_axis_tlast) begin
                     done_set  = 1'b1;
                     state_nxt = S_HDR;
                  end else begin
                     err_set   = 1'b1;
                     err_sel   = 2'b11;
                     state_nxt = S_DRAIN;
                  end
               end else if (s_axis_tlast) begin
                  err_set   = 1'b1;
                  err_sel   = 2'b10;
                  state_nxt = S_HDR;
               end
            end
         end
         S_DRAIN: begin
            tready_int = 1'b1;
            if (s_axis_tvalid && s_axis_tlast) state_nxt = S_HDR;
         end
         default: state_nxt = S_HDR;
      endcase
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         addr_q    <= '0;
         remaining <= '0;
         wr_en     <= 1'b0;
         wr_addr   <= '0;
         wr_data   <= '0;
         cmd_done  <= 1'b0;
         cmd_err   <= 1'b0;
         err_code  <= 2'b00;
         pkt_cnt   <= '0;
         err_cnt   <= '0;
      end else begin
         if (load_hdr) begin
            addr_q    <= s_axis_tdata[15:0];
            remaining <= s_axis_tdata[23:16];
         end
         if (load_word) begin
            wr_en     <= 1'b1;
            wr_data   <= s_axis_tdata;
            wr_addr   <= addr_q;
            addr_q    <= addr_q + 16'd1;
            remaining <= remaining - 8'd1;
         end else if (wr_ready) begin
            wr_en <= 1'b0;
         end
         cmd_done <= done_set;
         cmd_err  <= err_set;
         if (err_set) err_code <= err_sel;
         if (cmd_done && (pkt_cnt != '1)) pkt_cnt <= pkt_cnt + 16'd1;
         if (cmd_err  && (err_cnt != '1)) err_cnt <= err_cnt + 16'd1;
      end
   end

endmodule

// File: tb/tb_udp_cmd_rx.sv
// Scoreboard bench for udp_cmd_rx: expected writes and status pulses are queued
// as packets are driven and checked when the DUT produces them.
module tb_udp_cmd_rx;

   logic        aclk = 1'b0;
   logic        areset;
   logic [31:0] s_axis_tdata;
   logic        s_axis_tvalid;
   logic        s_axis_tlast;
   logic        s_axis_tready;
   logic        wr_en;
   logic [15:0] wr_addr;
   logic [31:0] wr_data;
   logic        wr_ready;
   logic        cmd_done;
   logic        cmd_err;
   logic [1:0]  err_code;
   logic [15:0] pkt_cnt;
   logic [15:0] err_cnt;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int rdy_mode = 0;   // 0: always ready, 1: toggle, 2: held low
   int exp_pkt = 0;
   int exp_err = 0;

   logic [47:0] wr_q[$];
   logic [1:0]  st_q[$];
   int          wr_cyc[$];

   udp_cmd_rx #(.MAX_LEN(64), .OPCODE_WR(8'hA5)) dut (
      .aclk(aclk), .areset(areset),
      .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
      .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
      .cmd_done(cmd_done), .cmd_err(cmd_err), .err_code(err_code),
      .pkt_cnt(pkt_cnt), .err_cnt(err_cnt)
   );

   always #5 aclk = ~aclk;
   always @(posedge aclk) cyc++;

   initial begin
      wr_ready = 1'b1;
      forever begin
         @(posedge aclk);
         #1;
         case (rdy_mode)
            0:       wr_ready = 1'b1;
            1:       wr_ready = ~wr_ready;
            default: wr_ready = 1'b0;
         endcase
      end
   end

   // Output monitor: pops the scoreboards on writes and status pulses
   logic        held_v = 1'b0;
   logic [47:0] held;
   always @(negedge aclk) begin
      logic [47:0] e;
      logic [1:0]  s, obs;
      if (!areset) begin
         if (wr_en && wr_ready) begin
            total++;
            if (wr_q.size() == 0) begin
               bad++;
               $display("FAIL unexpected_write got=%h:%h required=none", wr_addr, wr_data);
            end else begin
               e = wr_q.pop_front();
               if ({wr_addr, wr_data} !== e) begin
                  bad++;
                  $display("FAIL write got=%h:%h required=%h:%h", wr_addr, wr_data, e[47:32], e[31:0]);
               end
            end
            wr_cyc.push_back(cyc);
         end
         if (held_v && wr_en) begin
            total++;
            if ({wr_addr, wr_data} !== held) begin
               bad++;
               $display("FAIL stall_hold got=%h:%h required=%h:%h", wr_addr, wr_data, held[47:32], held[31:0]);
            end
         end
         held_v = wr_en && !wr_ready;
         held   = {wr_addr, wr_data};
         if (cmd_done || cmd_err) begin
            total++;
            if (cmd_done && cmd_err) begin
               bad++;
               $display("FAIL exclusive got=done&err required=one");
            end
            obs = cmd_done ? 2'b00 : err_code;
            total++;
            if (st_q.size() == 0) begin
               bad++;
               $display("FAIL unexpected_status got=%b required=none", obs);
            end else begin
               s = st_q.pop_front();
               if (obs !== s) begin
                  bad++;
                  $display("FAIL status got=%b required=%b", obs, s);
               end
            end
         end
      end else begin
         held_v = 1'b0;
      end
   end

   task automatic send(input logic [31:0] d, input logic last);
      logic ok = 1'b0;
      s_axis_tdata  = d;
      s_axis_tlast  = last;
      s_axis_tvalid = 1'b1;
      for (int k = 0; k < 100 && !ok; k++) begin
         @(negedge aclk);
         ok = s_axis_tready;
         @(posedge aclk);
         #1;
      end
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      if (!ok) begin
         total++;
         bad++;
         $display("FAIL tready_timeout got=0 required=1 word=%h", d);
      end
   endtask

   task automatic exp_wr(input logic [15:0] a, input logic [31:0] d);
      wr_q.push_back({a, d});
   endtask

   task automatic exp_st(input logic [1:0] c);
      st_q.push_back(c);
      if (c == 2'b00) exp_pkt++;
      else            exp_err++;
   endtask

   task automatic wait_idle();
      for (int k = 0; k < 200 && (wr_q.size() != 0 || st_q.size() != 0); k++)
         @(negedge aclk);
      total++;
      if (wr_q.size() != 0 || st_q.size() != 0) begin
         bad++;
         $display("FAIL drain_timeout got=%0d/%0d pending required=0/0", wr_q.size(), st_q.size());
         wr_q.delete();
         st_q.delete();
      end
      repeat (3) @(negedge aclk);
      total++;
      if (pkt_cnt !== 16'(exp_pkt)) begin
         bad++;
         $display("FAIL pkt_cnt got=%0d required=%0d", pkt_cnt, exp_pkt);
      end
      total++;
      if (err_cnt !== 16'(exp_err)) begin
         bad++;
         $display("FAIL err_cnt got=%0d required=%0d", err_cnt, exp_err);
      end
      @(posedge aclk);
      #1;
   endtask

   task automatic test_reset();
      areset = 1'b1;
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      s_axis_tdata  = '0;
      repeat (3) @(negedge aclk);
      total++;
      if ({s_axis_tready, wr_en, wr_addr, wr_data, cmd_done, cmd_err, err_code, pkt_cnt, err_cnt} !== '0) begin
         bad++;
         $display("FAIL reset_outputs got=%b%b %h %h %b%b %b %h %h required=all0",
                  s_axis_tready, wr_en, wr_addr, wr_data, cmd_done, cmd_err, err_code, pkt_cnt, err_cnt);
      end
      @(posedge aclk);
      #1;
      areset = 1'b0;
   endtask

   task automatic test_good_write();
      wr_cyc.delete();
      exp_wr(16'h0010, 32'h11);
      exp_wr(16'h0011, 32'h22);
      exp_wr(16'h0012, 32'h33);
      exp_st(2'b00);
      send(32'hA503_0010, 1'b0);
      send(32'h11, 1'b0);
      send(32'h22, 1'b0);
      send(32'h33, 1'b1);
      wait_idle();
      total++;
      if (wr_cyc.size() != 3 || (wr_cyc[2] - wr_cyc[0]) != 2) begin
         bad++;
         $display("FAIL throughput got=%0d writes over %0d cycles required=3 over 2",
                  wr_cyc.size(), (wr_cyc.size() == 3) ? wr_cyc[2] - wr_cyc[0] : -1);
      end
   endtask

   task automatic test_backpressure();
      rdy_mode = 1;
      exp_wr(16'h0010, 32'h11);
      exp_wr(16'h0011, 32'h22);
      exp_wr(16'h0012, 32'h33);
      exp_st(2'b00);
      send(32'hA503_0010, 1'b0);
      send(32'h11, 1'b0);
      send(32'h22, 1'b0);
      send(32'h33, 1'b1);
      wait_idle();
      rdy_mode = 0;
   endtask

   task automatic test_bad_header();
      exp_st(2'b01);
      send(32'h5A02_0000, 1'b0);
      send(32'h1, 1'b0);
      send(32'h2, 1'b0);
      send(32'h3, 1'b1);
      exp_wr(16'h0040, 32'hCAFE);
      exp_st(2'b00);
      send(32'hA501_0040, 1'b0);
      send(32'hCAFE, 1'b1);
      wait_idle();
   endtask

   task automatic test_short_long();
      exp_wr(16'h0100, 32'hA1);
      exp_wr(16'h0101, 32'hA2);
      exp_st(2'b10);
      send(32'hA504_0100, 1'b0);
      send(32'hA1, 1'b0);
      send(32'hA2, 1'b1);
      wait_idle();
      exp_wr(16'h0200, 32'hB1);
      exp_wr(16'h0201, 32'hB2);
      exp_st(2'b11);
      send(32'hA502_0200, 1'b0);
      for (int i = 1; i <= 5; i++) send(32'hB0 + 32'(i), i == 5);
      exp_wr(16'h0300, 32'hC1);
      exp_st(2'b00);
      send(32'hA501_0300, 1'b0);
      send(32'hC1, 1'b1);
      wait_idle();
   endtask

   task automatic test_limits();
      exp_st(2'b01);
      send(32'hA500_0000, 1'b0);
      send(32'h9, 1'b1);
      exp_st(2'b01);
      send(32'hA541_0000, 1'b0);
      send(32'h9, 1'b1);
      exp_st(2'b10);
      send(32'hA501_0000, 1'b1);
      exp_st(2'b01);
      send(32'h5A01_0000, 1'b1);
      exp_wr(16'hFFFF, 32'hE1);
      exp_wr(16'h0000, 32'hE2);
      exp_st(2'b00);
      send(32'hA502_FFFF, 1'b0);
      send(32'hE1, 1'b0);
      send(32'hE2, 1'b1);
      wait_idle();
      exp_wr(16'h0500, 32'hF0);
      exp_st(2'b00);
      send(32'hA540_0500, 1'b0);
      for (int i = 0; i < 64; i++) begin
         if (i > 0) exp_wr(16'h0500 + 16'(i), 32'hF0 + 32'(i));
         send(32'hF0 + 32'(i), i == 63);
      end
      wait_idle();
   endtask

   task automatic test_reset_mid();
      rdy_mode = 2;
      wr_ready = 1'b0;
      send(32'hA504_0400, 1'b0);
      send(32'hD1, 1'b0);
      #2;
      areset = 1'b1;
      #1;
      total++;
      if ({wr_en, s_axis_tready, cmd_done, cmd_err, pkt_cnt, err_cnt, err_code} !== '0) begin
         bad++;
         $display("FAIL async_reset got=wr_en:%b rdy:%b pkt:%0d err:%0d required=all0",
                  wr_en, s_axis_tready, pkt_cnt, err_cnt);
      end
      exp_pkt = 0;
      exp_err = 0;
      @(posedge aclk);
      #1;
      areset   = 1'b0;
      rdy_mode = 0;
      wr_ready = 1'b1;
      exp_wr(16'h0600, 32'hDEAD);
      exp_st(2'b00);
      send(32'hA501_0600, 1'b0);
      send(32'hDEAD, 1'b1);
      wait_idle();
   endtask

   initial begin
      test_reset();
      test_good_write();
      test_backpressure();
      test_bad_header();
      test_short_long();
      test_limits();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=running required=finished");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/udp_cmd_rx.md
# udp_cmd_rx

Command decoder on the user side of the Ethernet receive path. Consumes 32-bit AXI-Stream UDP payload packets from the receive asynchronous FIFO output, in the `aclk` domain, and interprets each packet as one write command: a header word followed by data words. Data words are issued on a registered write port with backpressure toward a register file or memory. Malformed packets are reported and discarded, and completed and failed commands are counted.

## Interface
- `MAX_LEN`, default 64: maximum accepted data-word count per command (1..255).
- `OPCODE_WR`, default 8'hA5: header opcode for a write command.

Ports (name, direction, width, meaning):
- `aclk`  in  1  clock.
- `areset`  in  1  asynchronous reset, active high.
- `s_axis_tdata`  in  32  payload word from the receive FIFO.
- `s_axis_tvalid`  in  1  word valid.
- `s_axis_tlast`  in  1  last word of the UDP payload.
- `s_axis_tready`  out  1  word accepted when high together with `s_axis_tvalid`.
- `wr_en`  out  1  write request, held until accepted.
- `wr_addr`  out  16  word address of the write.
- `wr_data`  out  32  write data.
- `wr_ready`  in  1  sink accepts the write when high together with `wr_en`.
- `cmd_done`  out  1  one-cycle pulse: command completed without error.
- `cmd_err`  out  1  one-cycle pulse: command rejected or aborted.
- `err_code`  out  2  cause of the last error: 01 bad header, 10 short packet, 11 long packet. Holds its value until the next error.
- `pkt_cnt`  out  16  count of completed commands, saturating.
- `err_cnt`  out  16  count of errors, saturating.

## Operation
- **Header word layout:** [31:24] opcode, [23:16] LEN (number of data words), [15:0] start address.
- **State machine:** HDR, DATA, DRAIN.
- **HDR:**
  - `s_axis_tready`=1.
  - On handshake, the header is valid when opcode==`OPCODE_WR`, 1<=LEN<=`MAX_LEN`, and tlast=0.
  - Valid header: load the address register, load remaining=LEN, go to DATA.
  - tlast=1 on the header word: `err_code`=10, stay in HDR.
  - Bad opcode or bad LEN with tlast=0: `err_code`=01, go to DRAIN.
  - Bad opcode or bad LEN with tlast=1: `err_code`=01, stay in HDR.
- **DATA:**
  - `s_axis_tready` = !`wr_en` | `wr_ready`.
  - On handshake: `wr_en`<=1, `wr_data`<=tdata, `wr_addr`<=address register. The address register then increments by 1 and wraps from 16'hFFFF to 16'h0000. remaining decrements by 1.
  - remaining==1 and tlast=1: `cmd_done`, go to HDR.
  - remaining==1 and tlast=0: `err_code`=11, go to DRAIN.
  - remaining>1 and tlast=1: `err_code`=10, go to HDR.
- **Partial writes:** words already written before an error are not rolled back. The word carrying the error condition is still written.
- **DRAIN:** `s_axis_tready`=1; words are discarded. Go to HDR on the tlast handshake.
- **Write port:** `wr_en` clears after a `wr_ready` handshake unless a new word is loaded in the same cycle. `wr_data` and `wr_addr` are stable while `wr_en`=1 and `wr_ready`=0.
- **Counters:** `pkt_cnt` increments with each `cmd_done`, `err_cnt` with each `cmd_err`. Both saturate at 16'hFFFF.

## Timing
- **Reset values:** all outputs 0, state HDR, `err_code`=00, counters 0. Reset is asynchronous, so `wr_en` drops immediately even mid-command. The next packet after reset release is parsed as a header.
- **Write latency:** a data word handshake in cycle N gives `wr_en`/`wr_data`/`wr_addr` valid in cycle N+1.
- **Throughput:** one word per cycle while `wr_ready`=1.
- **Backpressure:** `wr_ready`=0 with `wr_en`=1 forces `s_axis_tready`=0 in the same cycle (combinational).
- **Status pulses:** `cmd_done` and `cmd_err` are registered and assert in cycle N+1 after the deciding handshake in cycle N. `err_code` updates in that same cycle.
- **Counter timing:** counters update in the cycle after the corresponding pulse.
- **Exclusivity:** `cmd_done` and `cmd_err` are never high together.
- **Idle input:** `s_axis_tvalid`=0 in any state holds state, counters and address unchanged.

## Test plan
- **Good write:**
  - Stimulus: header 32'hA5_03_0010, then words 11, 22, 33 with tlast on 33, `wr_ready`=1.
  - Response: writes (0010,11), (0011,22), (0012,33) on consecutive cycles; one `cmd_done`; `pkt_cnt`=1.
- **Backpressure:**
  - Stimulus: same packet with `wr_ready` toggling 0/1 every cycle.
  - Response: identical write sequence; data and address stable while stalled; no word lost.
- **Bad header:**
  - Stimulus: header 32'h5A_02_0000 followed by 3 words, tlast on the third.
  - Response: no writes; `cmd_err` with `err_code`=01; all words drained; the next good packet is decoded correctly.
- **Short and long packets:**
  - Short: LEN=4 with tlast on the 2nd data word gives 2 writes, `err_code`=10.
  - Long: LEN=2 with 5 data words gives 2 writes, `err_code`=11, and the remaining 3 words are drained.
- **Limits:**
  - LEN=0 gives `err_code`=01.
  - LEN=`MAX_LEN`+1 gives `err_code`=01.
  - Start address 16'hFFFF with LEN=2 writes to FFFF then 0000.
- **Reset mid-command:** assert `areset` after the 1st data word of LEN=4. All outputs go to 0 asynchronously; the next packet after release is parsed as a header.
